enemy_hit_detect: RTL and testbench
===================================

Name: enemy_hit_detect

Overview:
Per-pixel collision front end for one enemy. Sits directly upstream of the enemy motion FSM and drives its collision, HitEdgeCode and valid_enemy_pos inputs. Compares the enemy draw request with the obstacle draw request (walls, bricks, bombs) on every scanned pixel and classifies each overlap by which sprite edge it touches. Debounces the hits and issues at most one edge report per frame.

Parameters:
OBJECT_WIDTH, 32, sprite width in pixels
OBJECT_HEIGHT, 32, sprite height in pixels
EDGE_BAND, 4, depth in pixels of each edge band, measured inward from that edge
MIN_HITS, 2, overlap pixels needed on one edge in a frame before it is reported (1..15)

Ports:
clk  in  1  system clock
resetN  in  1  reset
startOfFrame  in  1  one-clk pulse at start of each frame
pixelX  in  11  current scan X
pixelY  in  11  current scan Y
topLeftX  in  11 signed  enemy top-left X from the motion block
topLeftY  in  11 signed  enemy top-left Y from the motion block
enemyDR  in  1  enemy sprite draw request
obstacleDR  in  1  OR of all blocking-object draw requests
direction  in  4  current one-hot move direction from the motion block
collision  out  1  one-clk hit pulse
HitEdgeCode  out  4  one-hot edge hit: TOP=0100, RIGHT=0010, LEFT=1000, BOTTOM=0001; 0000 = none
valid_enemy_pos  out  1  previous frame had no interior overlap

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk. All outputs are 0 and the FSM is in WAIT_FRAME.
- Stage 1 (register): hitRaw = enemyDR & obstacleDR.
  - offX = pixelX - topLeftX and offY = pixelY - topLeftY, computed as 12-bit signed.
  - Registered together with direction.
  - If offX is outside 0..OBJECT_WIDTH-1 or offY is outside 0..OBJECT_HEIGHT-1, hitRaw is forced to 0.
- Classification (combinational on stage-1 registers). Candidate edges:
  - TOP if offY < EDGE_BAND
  - BOTTOM if offY >= OBJECT_HEIGHT - EDGE_BAND
  - LEFT if offX < EDGE_BAND
  - RIGHT if offX >= OBJECT_WIDTH - EDGE_BAND
- Corner rule (two candidates): pick the one equal to direction; otherwise pick the vertical edge (TOP or BOTTOM).
- Interior rule: if hitRaw is set and no candidate applies, the pixel sets the interior flag and produces no edge.
- Stage 2: per-edge 4-bit hit counters, saturating at 15, each incremented by a classified hit.
- Latency: an overlap pixel sampled at cycle N updates its counter at N+2. collision is high exactly during cycle N+2 if that update brings the counter to MIN_HITS.
- FSM states:
  - WAIT_FRAME: ignore all hits. startOfFrame -> COLLECT.
  - COLLECT: count hits. When the first edge counter reaches MIN_HITS: pulse collision, load HitEdgeCode with that edge, go to REPORTED.
  - REPORTED: keep counting (counters only), no further pulses, HitEdgeCode held.
- startOfFrame in any state:
  - Clear all counters, HitEdgeCode and collision.
  - Set valid_enemy_pos = ~interiorFlag, then clear interiorFlag.
  - Go to COLLECT.
- Simultaneous startOfFrame and a pipeline hit in the same cycle: startOfFrame wins and the hit is discarded.
- If two edges reach MIN_HITS in the same cycle (impossible for one pixel, kept for safety), priority is TOP > BOTTOM > LEFT > RIGHT.
- MIN_HITS = 1: collision pulses on the first classified hit.
- Negative topLeft values (sprite partly offscreen) follow the same signed offset arithmetic.

Optional Feature:
ENEMY_HIT_LEAD_EDGE_EN
- Defined: only hits on the edge equal to direction are counted. Other edges neither count nor set the interior flag, which prevents reports from an obstacle the enemy is moving away from.
- Undefined: all four edges are counted as above.

Decomposition:
- Package enemy_pkg:
  - edge_t constants TOP/RIGHT/LEFT/BOTTOM (shared with the motion block)
  - OBJECT_WIDTH_X/OBJECT_HIGHT_Y defaults
  - FIXED_POINT_MULTIPLIER
  - FSM enum hit_state_t
- Sub-module enemy_edge_classify (combinational): takes offX, offY and direction; returns a one-hot edge and an interior flag. Instantiated once.

Test Plan:
- Right-edge debounce: topLeft=(100,200), direction=0010, obstacleDR&enemyDR at (130,210),(131,210) -> counter RIGHT=2; collision pulses 1 clk at 2 clks after pixel (131,210); HitEdgeCode=0010 until next startOfFrame.
- Single pixel below threshold: MIN_HITS=2, one overlap at (100,200) (offset 0,0) -> corner TOP vs LEFT; direction=0001 so TOP wins; counter TOP=1; no collision; HitEdgeCode stays 0000.
- Corner preference: same pixel with direction=1000 and a second hit at (101,200) -> both LEFT; collision with HitEdgeCode=1000.
- One report per frame: hits reach MIN_HITS on TOP, then 5 BOTTOM hits -> one collision pulse with 0100; next startOfFrame clears HitEdgeCode to 0000.
- Interior overlap: overlap at (116,216) (offset 16,16) -> no collision; at next startOfFrame valid_enemy_pos=0; a following clean frame gives valid_enemy_pos=1.
- Reset and conflict: overlap coincident with startOfFrame -> discarded, counters 0. resetN low mid-REPORTED -> all outputs 0 and WAIT_FRAME; hits ignored until first startOfFrame. With ENEMY_HIT_LEAD_EDGE_EN and direction=0010, LEFT hits -> no pulse.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared enemy definitions: edge codes, sprite defaults and hit-detect FSM states.
package enemy_pkg;

  typedef logic [3:0] edge_t;

  localparam edge_t TOP     = 4'b0100;
  localparam edge_t RIGHT   = 4'b0010;
  localparam edge_t LEFT    = 4'b1000;
  localparam edge_t BOTTOM  = 4'b0001;
  localparam edge_t NO_EDGE = 4'b0000;

  localparam int unsigned OBJECT_WIDTH_X         = 32;
  localparam int unsigned OBJECT_HIGHT_Y         = 32;
  localparam int unsigned FIXED_POINT_MULTIPLIER = 64;

  // Signed width of the pixel-to-sprite offsets
  localparam int unsigned OFF_W = 12;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    COLLECT,
    REPORTED
  } hit_state_t;

endpackage

// File: rtl/enemy_hit_detect_classify.sv
// enemy_edge_classify: maps an in-sprite offset to one edge (or interior).
// Corner pixels prefer the edge the enemy is moving toward, else the vertical edge.
module enemy_edge_classify
  import enemy_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH  = OBJECT_WIDTH_X,
  parameter int unsigned OBJECT_HEIGHT = OBJECT_HIGHT_Y,
  parameter int unsigned EDGE_BAND     = 4
) (
  input  logic signed [OFF_W-1:0] off_x,
  input  logic signed [OFF_W-1:0] off_y,
  input  logic        [3:0]       direction,
  output edge_t                   edge_c,
  output logic                    interior_c
);

  logic       is_top;
  logic       is_bottom;
  logic       is_left;
  logic       is_right;
  edge_t      cand;
  logic [2:0] n_cand;
  logic       dir_match;

  assign is_top    = off_y <  $signed(OFF_W'(EDGE_BAND));
  assign is_bottom = off_y >= $signed(OFF_W'(OBJECT_HEIGHT - EDGE_BAND));
  assign is_left   = off_x <  $signed(OFF_W'(EDGE_BAND));
  assign is_right  = off_x >= $signed(OFF_W'(OBJECT_WIDTH - EDGE_BAND));

  // Resolve candidate bands into a single edge or the interior flag
  always_comb begin
    cand = ({4{is_top}} & TOP) | ({4{is_bottom}} & BOTTOM) |
           ({4{is_left}} & LEFT) | ({4{is_right}} & RIGHT);
    n_cand = 3'(is_top) + 3'(is_bottom) + 3'(is_left) + 3'(is_right);
    dir_match = (direction inside {TOP, RIGHT, LEFT, BOTTOM}) && ((cand & direction) != NO_EDGE);
    edge_c     = NO_EDGE;
    interior_c = 1'b0;
    if (n_cand == 3'd0) begin
      interior_c = 1'b1;
    end else if (n_cand == 3'd1) begin
      edge_c = cand;
    end else if (dir_match) begin
      edge_c = direction;
    end else begin
      edge_c = cand & (TOP | BOTTOM);
    end
  end

endmodule

// File: rtl/enemy_hit_detect.sv
// enemy_hit_detect: per-pixel enemy/obstacle overlap classifier with per-frame
// debounced edge report. Optional macro ENEMY_HIT_LEAD_EDGE_EN restricts
// counting to the edge matching the current move direction.
module enemy_hit_detect
  import enemy_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH  = OBJECT_WIDTH_X,
  parameter int unsigned OBJECT_HEIGHT = OBJECT_HIGHT_Y,
  parameter int unsigned EDGE_BAND     = 4,
  parameter int unsigned MIN_HITS      = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               enemyDR,
  input  logic               obstacleDR,
  input  logic        [3:0]  direction,
  output logic               collision,
  output logic        [3:0]  HitEdgeCode,
  output logic               valid_enemy_pos
);

  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] MIN_CNT = 4'(MIN_HITS);

  logic signed [OFF_W-1:0] off_x_c;
  logic signed [OFF_W-1:0] off_y_c;
  logic                    in_box_c;
  logic                    hit_raw_q;
  logic signed [OFF_W-1:0] off_x_q;
  logic signed [OFF_W-1:0] off_y_q;
  logic        [3:0]       dir_q;

  edge_t      edge_c;
  logic       interior_c;
  edge_t      count_edge_c;
  logic       interior_hit_c;
  logic [3:0] reach_c;
  edge_t      first_c;

  hit_state_t       state_q;
  hit_state_t       state_d;
  logic [3:0][3:0]  cnt_q;
  logic [3:0][3:0]  cnt_d;
  edge_t            edge_d;
  logic             coll_d;
  logic             valid_d;
  logic             interior_q;
  logic             interior_d;

  assign off_x_c  = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y_c  = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
  assign in_box_c = !off_x_c[OFF_W-1] && (off_x_c[OFF_W-2:0] < 11'(OBJECT_WIDTH)) &&
                    !off_y_c[OFF_W-1] && (off_y_c[OFF_W-2:0] < 11'(OBJECT_HEIGHT));

  // Stage 1: register the in-sprite overlap, offsets and direction
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_raw_q <= 1'b0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      dir_q     <= '0;
    end else begin
      hit_raw_q <= enemyDR & obstacleDR & in_box_c;
      off_x_q   <= off_x_c;
      off_y_q   <= off_y_c;
      dir_q     <= direction;
    end
  end

  enemy_edge_classify #(
    .OBJECT_WIDTH (OBJECT_WIDTH),
    .OBJECT_HEIGHT(OBJECT_HEIGHT),
    .EDGE_BAND    (EDGE_BAND)
  ) u_classify (
    .off_x     (off_x_q),
    .off_y     (off_y_q),
    .direction (dir_q),
    .edge_c    (edge_c),
    .interior_c(interior_c)
  );

`ifdef ENEMY_HIT_LEAD_EDGE_EN
  assign count_edge_c = (hit_raw_q && (edge_c == dir_q)) ? edge_c : NO_EDGE;
`else
  assign count_edge_c = hit_raw_q ? edge_c : NO_EDGE;
`endif
  assign interior_hit_c = hit_raw_q & interior_c;

  // Edges whose counter lands exactly on the threshold this cycle, with priority pick
  always_comb begin
    reach_c = '0;
    for (int i = 0; i < 4; i++) begin
      reach_c[i] = count_edge_c[i] && (cnt_q[i] != CNT_MAX) && ((cnt_q[i] + 4'd1) == MIN_CNT);
    end
    first_c = NO_EDGE;
    if ((reach_c & TOP) != NO_EDGE)         first_c = TOP;
    else if ((reach_c & BOTTOM) != NO_EDGE) first_c = BOTTOM;
    else if ((reach_c & LEFT) != NO_EDGE)   first_c = LEFT;
    else if ((reach_c & RIGHT) != NO_EDGE)  first_c = RIGHT;
  end

  // Hit FSM next state, counters and report outputs; frame start overrides any hit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = HitEdgeCode;
    coll_d     = 1'b0;
    valid_d    = valid_enemy_pos;
    interior_d = interior_q;
    if (startOfFrame) begin
      cnt_d      = '0;
      edge_d     = NO_EDGE;
      valid_d    = ~interior_q;
      interior_d = 1'b0;
      state_d    = COLLECT;
    end else begin
      unique case (state_q)
        WAIT_FRAME: ;
        COLLECT, REPORTED: begin
          if (interior_hit_c) interior_d = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (count_edge_c[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + 4'd1;
          end
          if ((state_q == COLLECT) && (first_c != NO_EDGE)) begin
            coll_d  = 1'b1;
            edge_d  = first_c;
            state_d = REPORTED;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= WAIT_FRAME;
      cnt_q           <= '0;
      collision       <= 1'b0;
      HitEdgeCode     <= NO_EDGE;
      valid_enemy_pos <= 1'b0;
      interior_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      collision       <= coll_d;
      HitEdgeCode     <= edge_d;
      valid_enemy_pos <= valid_d;
      interior_q      <= interior_d;
    end
  end

endmodule

// File: tb/tb_enemy_hit_detect.sv
// Self-checking bench for enemy_hit_detect: directed scenarios with literal
// expectations plus randomized frames against a behavioural model.
module tb_enemy_hit_detect;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int B    = 4;
  localparam int MINH = 2;
  localparam logic [3:0] E_TOP   = 4'b0100;
  localparam logic [3:0] E_RIGHT = 4'b0010;
  localparam logic [3:0] E_LEFT  = 4'b1000;
  localparam logic [3:0] E_BOT   = 4'b0001;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic        [10:0] pixelX = '0;
  logic        [10:0] pixelY = '0;
  logic signed [10:0] topLeftX = '0;
  logic signed [10:0] topLeftY = '0;
  logic               enemyDR = 1'b0;
  logic               obstacleDR = 1'b0;
  logic        [3:0]  direction = '0;
  logic               collision;
  logic        [3:0]  HitEdgeCode;
  logic               valid_enemy_pos;

  int checks = 0;
  int errors = 0;

  enemy_hit_detect dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .enemyDR        (enemyDR),
    .obstacleDR     (obstacleDR),
    .direction      (direction),
    .collision      (collision),
    .HitEdgeCode    (HitEdgeCode),
    .valid_enemy_pos(valid_enemy_pos)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state: counts per edge, frame flags, and one pixel of pipeline delay
  int         m_cnt[4];
  bit         m_active, m_reported, m_interior, m_coll, m_valid;
  logic [3:0] m_edge;
  logic [3:0] p_edge;
  bit         p_int;
  logic [3:0] n_edge;
  bit         n_int;
  int         k;

  function automatic int idx(input logic [3:0] e);
    case (e)
      E_TOP:   return 0;
      E_BOT:   return 1;
      E_LEFT:  return 2;
      default: return 3;
    endcase
  endfunction

  // Classify one pixel directly from screen coordinates
  function automatic void classify(input int px, input int py, input int tlx, input int tly,
                                   input logic [3:0] dir, input bit hit,
                                   output logic [3:0] e, output bit intr);
    int ox, oy, n;
    bit t, bo, l, r;
    ox = px - tlx;
    oy = py - tly;
    e = 4'b0000;
    intr = 1'b0;
    if (!hit || ox < 0 || ox >= W || oy < 0 || oy >= H) return;
    t  = (oy < B);
    bo = (oy >= H - B);
    l  = (ox < B);
    r  = (ox >= W - B);
    n  = int'(t) + int'(bo) + int'(l) + int'(r);
    if (n == 0) intr = 1'b1;
    else if (n == 1) e = t ? E_TOP : (bo ? E_BOT : (l ? E_LEFT : E_RIGHT));
    else if ((dir == E_TOP && t) || (dir == E_BOT && bo) || (dir == E_LEFT && l) || (dir == E_RIGHT && r))
      e = dir;
    else e = t ? E_TOP : E_BOT;
`ifdef ENEMY_HIT_LEAD_EDGE_EN
    if (e != dir) e = 4'b0000;
`endif
  endfunction

  // Model update on each clock edge, then compare all outputs
  always @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_active = 0; m_reported = 0; m_interior = 0; m_coll = 0; m_valid = 0;
      m_edge = 4'b0000; p_edge = 4'b0000; p_int = 0;
    end else begin
      m_coll = 0;
      if (startOfFrame) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_edge = 4'b0000;
        m_valid = !m_interior;
        m_interior = 0;
        m_active = 1;
        m_reported = 0;
      end else if (m_active) begin
        if (p_int) m_interior = 1;
        if (p_edge != 4'b0000) begin
          k = idx(p_edge);
          if (m_cnt[k] < 15) begin
            m_cnt[k]++;
            if (!m_reported && m_cnt[k] == MINH) begin
              m_coll = 1;
              m_edge = p_edge;
              m_reported = 1;
            end
          end
        end
      end
      classify(int'(pixelX), int'(pixelY), int'(topLeftX), int'(topLeftY), direction,
               enemyDR && obstacleDR, n_edge, n_int);
      p_edge = n_edge;
      p_int = n_int;
    end
    #1;
    check("model_collision", int'(collision), int'(m_coll));
    check("model_edge", int'(HitEdgeCode), int'(m_edge));
    check("model_valid", int'(valid_enemy_pos), int'(m_valid));
  end

  task automatic drive(input int x, input int y, input bit hit, input bit sof);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    enemyDR = hit;
    obstacleDR = hit;
    startOfFrame = sof;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0);
  endtask

  task automatic sof();
    drive(0, 0, 0, 1);
  endtask

  int tlx, tly, px, py;

  initial begin
    topLeftX = 11'sd100;
    topLeftY = 11'sd200;
    direction = E_RIGHT;
    drive(100, 200, 1, 0);
    drive(101, 200, 1, 0);
    check("rst_collision", int'(collision), 0);
    check("rst_edge", int'(HitEdgeCode), 0);
    check("rst_valid", int'(valid_enemy_pos), 0);
    resetN = 1'b1;

    // Hits before the first frame start are ignored
    drive(130, 210, 1, 0); drive(131, 210, 1, 0); idle(); idle();
    check("pre_frame_collision", int'(collision), 0);
    check("pre_frame_edge", int'(HitEdgeCode), 0);

    // Right-edge debounce
    sof(); direction = E_RIGHT;
    drive(130, 210, 1, 0); drive(131, 210, 1, 0); idle(); idle();
    check("right_pulse", int'(collision), 1);
    check("right_edge", int'(HitEdgeCode), int'(E_RIGHT));
    idle();
    check("right_pulse_end", int'(collision), 0);
    idle(); idle();
    check("right_edge_held", int'(HitEdgeCode), int'(E_RIGHT));

    // Single corner pixel below threshold
    sof(); direction = E_BOT; idle();
    check("clean_valid", int'(valid_enemy_pos), 1);
    check("sof_edge_clear", int'(HitEdgeCode), 0);
    drive(100, 200, 1, 0); idle(); idle();
    check("single_no_pulse", int'(collision), 0);
    idle();
    check("single_edge_none", int'(HitEdgeCode), 0);

    // Corner preference toward direction
    sof(); direction = E_LEFT;
    drive(100, 200, 1, 0); drive(101, 200, 1, 0); idle(); idle();
    check("corner_pulse", int'(collision), 1);
    check("corner_edge", int'(HitEdgeCode), int'(E_LEFT));

    // One report per frame
    sof(); direction = E_TOP;
    drive(110, 200, 1, 0); drive(111, 200, 1, 0); idle(); idle();
    check("top_pulse", int'(collision), 1);
    check("top_edge", int'(HitEdgeCode), int'(E_TOP));
    for (int i = 0; i < 5; i++) drive(110 + i, 231, 1, 0);
    idle(); idle();
    check("second_no_pulse", int'(collision), 0);
    check("second_edge_held", int'(HitEdgeCode), int'(E_TOP));
    sof(); idle();
    check("next_frame_clear", int'(HitEdgeCode), 0);

    // Interior overlap invalidates the position for one frame
    drive(116, 216, 1, 0); idle(); idle();
    check("interior_no_pulse", int'(collision), 0);
    sof(); idle();
    check("interior_invalid", int'(valid_enemy_pos), 0);
    sof(); idle();
    check("interior_recovers", int'(valid_enemy_pos), 1);

    // Pipeline hit coincident with frame start is discarded
    direction = E_TOP;
    drive(110, 200, 1, 0); sof(); drive(111, 200, 1, 0); idle(); idle();
    check("conflict_no_pulse", int'(collision), 0);
    drive(112, 200, 1, 0); idle(); idle();
    check("conflict_then_pulse", int'(collision), 1);
    check("conflict_edge", int'(HitEdgeCode), int'(E_TOP));

    // Reset while reported
    idle(); resetN = 1'b0; #1;
    check("midrst_collision", int'(collision), 0);
    check("midrst_edge", int'(HitEdgeCode), 0);
    check("midrst_valid", int'(valid_enemy_pos), 0);
    idle(); resetN = 1'b1;
    drive(110, 200, 1, 0); drive(111, 200, 1, 0); idle(); idle();
    check("postrst_no_pulse", int'(collision), 0);
    check("postrst_edge", int'(HitEdgeCode), 0);

    // Left hits while moving right
    sof(); direction = E_RIGHT;
    drive(100, 210, 1, 0); drive(101, 210, 1, 0); idle(); idle();
`ifdef ENEMY_HIT_LEAD_EDGE_EN
    check("lead_left_pulse", int'(collision), 0);
    check("lead_left_edge", int'(HitEdgeCode), 0);
`else
    check("lead_left_pulse", int'(collision), 1);
    check("lead_left_edge", int'(HitEdgeCode), int'(E_LEFT));
`endif

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      tlx = int'($urandom_range(0, 320)) - 20;
      tly = int'($urandom_range(0, 320)) - 20;
      topLeftX = 11'(tlx);
      topLeftY = 11'(tly);
      sof();
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        case ($urandom % 5)
          0: direction = E_TOP;
          1: direction = E_RIGHT;
          2: direction = E_LEFT;
          3: direction = E_BOT;
          default: direction = 4'($urandom);
        endcase
        px = tlx + int'($urandom_range(0, 40)) - 4;
        py = tly + int'($urandom_range(0, 40)) - 4;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        pixelX = 11'(px);
        pixelY = 11'(py);
        enemyDR = ($urandom % 4) != 0;
        obstacleDR = ($urandom % 3) == 0;
        startOfFrame = ($urandom % 40) == 0;
        resetN = ($urandom % 200) != 0;
      end
      @(negedge clk);
      resetN = 1'b1;
    end

    idle(); idle(); idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
